tod_splitter: RTL and testbench

- Converts a GNSS-derived binary seconds-of-day count into separate binary hours, minutes and seconds fields.
- Sits directly upstream of the binary-to-BCD converters that build the HaveQuick time-of-day word. Each field feeds one converter instance (INPUT_WIDTH=8, DECIMAL_DIGITS=2), zero-extended to 8 bits. o_DV drives their i_Start.
- Uses sequential shift-subtract division (divide by 3600, then the remainder by 60), so it needs no hardware divider.

---
 rtl/tod_splitter.sv | 158 +++++++++++++++
 tb/tb_tod_splitter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tod_splitter.sv
// Seconds-of-day to hours/minutes/seconds splitter using two sequential
// restoring divisions (by 3600, then the remainder by 60).
module tod_splitter #(
  parameter int unsigned SOD_WIDTH = 17,
  parameter int unsigned MAX_SOD   = 86399
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [SOD_WIDTH-1:0] i_SOD,
  input  logic                 i_Start,
  output logic                 o_Busy,
  output logic [4:0]           o_Hours,
  output logic [5:0]           o_Minutes,
  output logic [5:0]           o_Seconds,
  output logic                 o_Err,
  output logic                 o_DV
);

  localparam int unsigned CntRaw = $clog2(SOD_WIDTH + 1);
  localparam int unsigned CntW   = (CntRaw > 5) ? CntRaw : 5;

  typedef enum logic [1:0] {StIdle, StDivH, StDivM} state_e;

  state_e                 state_q, state_d;
  logic [SOD_WIDTH-1:0]   dividend_q, dividend_d;
  logic [SOD_WIDTH-1:0]   quot_q, quot_d;
  logic [12:0]            rem_q, rem_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [4:0]             hrs_q, hrs_d;
  logic                   busy_q, busy_d;
  logic [4:0]             hours_q, hours_d;
  logic [5:0]             minutes_q, minutes_d;
  logic [5:0]             seconds_q, seconds_d;
  logic                   err_q, err_d;
  logic                   dv_q, dv_d;

  // One restoring-division step shared by both phases.
  logic                   div_msb;
  logic [12:0]            divisor;
  logic [12:0]            rem_shift;
  logic                   rem_ge;
  logic [12:0]            rem_next;
  logic [SOD_WIDTH-1:0]   quot_next;

  always_comb begin
    div_msb   = (state_q == StDivH) ? dividend_q[SOD_WIDTH-1] : dividend_q[11];
    divisor   = (state_q == StDivH) ? 13'd3600 : 13'd60;
    rem_shift = {rem_q[11:0], div_msb};
    rem_ge    = (rem_shift >= divisor);
    rem_next  = rem_ge ? (rem_shift - divisor) : rem_shift;
    quot_next = {quot_q[SOD_WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    hrs_d      = hrs_q;
    busy_d     = busy_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    err_d      = err_q;
    dv_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          if (i_SOD > SOD_WIDTH'(MAX_SOD)) begin
            err_d     = 1'b1;
            hours_d   = '0;
            minutes_d = '0;
            seconds_d = '0;
            dv_d      = 1'b1;
          end else begin
            dividend_d = i_SOD;
            quot_d     = '0;
            rem_d      = '0;
            cnt_d      = '0;
            busy_d     = 1'b1;
            state_d    = StDivH;
          end
        end
      end
      StDivH: begin
        dividend_d = {dividend_q[SOD_WIDTH-2:0], 1'b0};
        quot_d     = quot_next;
        rem_d      = rem_next;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CntW'(SOD_WIDTH - 1)) begin
          // Remainder < 3600 fits in 12 bits and becomes the minutes dividend.
          hrs_d      = quot_next[4:0];
          dividend_d = {{(SOD_WIDTH-12){1'b0}}, rem_next[11:0]};
          quot_d     = '0;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = StDivM;
        end
      end
      StDivM: begin
        dividend_d = {dividend_q[SOD_WIDTH-2:0], 1'b0};
        quot_d     = quot_next;
        rem_d      = rem_next;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CntW'(11)) begin
          hours_d   = hrs_q;
          minutes_d = quot_next[5:0];
          seconds_d = rem_next[5:0];
          err_d     = 1'b0;
          dv_d      = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      hrs_q      <= '0;
      busy_q     <= 1'b0;
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
      err_q      <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      hrs_q      <= hrs_d;
      busy_q     <= busy_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      err_q      <= err_d;
      dv_q       <= dv_d;
    end
  end

  assign o_Busy    = busy_q;
  assign o_Hours   = hours_q;
  assign o_Minutes = minutes_q;
  assign o_Seconds = seconds_q;
  assign o_Err     = err_q;
  assign o_DV      = dv_q;

endmodule

// File: tb/tb_tod_splitter.sv
// Self-checking bench for tod_splitter: directed vector table, hand-written
// corner sequences and a randomized sweep against an arithmetic model.
module tb_tod_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] sod;
  logic        start;
  logic        busy;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic        err;
  logic        dv;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tod_splitter #(
    .SOD_WIDTH(17),
    .MAX_SOD  (86399)
  ) dut (
    .i_Clock  (clk),
    .i_Reset  (rst),
    .i_SOD    (sod),
    .i_Start  (start),
    .o_Busy   (busy),
    .o_Hours  (hours),
    .o_Minutes(minutes),
    .o_Seconds(seconds),
    .o_Err    (err),
    .o_DV     (dv)
  );

  typedef struct {
    int unsigned sod;
    bit          err;
    int          h;
    int          m;
    int          s;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Leaves the caller 1 time unit after the accepting edge.
  task automatic start_req(input int unsigned v);
    sod   = 17'(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = edges after the accepting edge at which o_DV was seen.
  task automatic wait_dv(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = 0;
    while (!dv && lat < 64) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!dv) chk("dv_timeout", 0, 1);
  endtask

  task automatic do_conv(input string nm, input int unsigned v, input bit e,
                         input int h, input int m, input int s);
    int lat, bc;
    start_req(v);
    wait_dv(lat, bc);
    chk({nm, "_latency"}, lat, e ? 0 : 29);
    chk({nm, "_busy_cycles"}, bc, e ? 0 : 29);
    chk({nm, "_busy_at_dv"}, busy, 0);
    chk({nm, "_err"}, err, e);
    chk({nm, "_hours"}, hours, h);
    chk({nm, "_minutes"}, minutes, m);
    chk({nm, "_seconds"}, seconds, s);
  endtask

  task automatic expect_no_dv(input string nm, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (dv) seen++;
    end
    chk(nm, seen, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int lat, bc;
    int unsigned r;

    vecs[0] = '{sod: 0,      err: 0, h: 0,  m: 0,  s: 0};
    vecs[1] = '{sod: 45296,  err: 0, h: 12, m: 34, s: 56};
    vecs[2] = '{sod: 86399,  err: 0, h: 23, m: 59, s: 59};
    vecs[3] = '{sod: 86400,  err: 1, h: 0,  m: 0,  s: 0};
    vecs[4] = '{sod: 3661,   err: 0, h: 1,  m: 1,  s: 1};
    vecs[5] = '{sod: 131071, err: 1, h: 0,  m: 0,  s: 0};
    vecs[6] = '{sod: 3661,   err: 0, h: 1,  m: 1,  s: 1};
    vecs[7] = '{sod: 50000,  err: 0, h: 13, m: 53, s: 20};

    rst   = 1'b1;
    sod   = '0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_dv", dv, 0);
    chk("reset_err", err, 0);
    chk("reset_fields", {hours, minutes, seconds}, 0);

    // Back-to-back table: each start is issued in the cycle after o_DV.
    for (int i = 0; i < 8; i++) begin
      do_conv($sformatf("vec%0d", i), vecs[i].sod, vecs[i].err,
              vecs[i].h, vecs[i].m, vecs[i].s);
    end
    @(posedge clk);
    #1;
    chk("table_dv_width", dv, 0);

    // Start ignored while busy; i_SOD churns during the conversion.
    start_req(3599);
    fork
      wait_dv(lat, bc);
      begin
        repeat (9) begin
          @(posedge clk);
          #2 sod = 17'($urandom);
        end
        sod   = 17'd100;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (30) begin
          @(posedge clk);
          #2 sod = 17'($urandom);
        end
      end
    join
    chk("ignore_latency", lat, 29);
    chk("ignore_err", err, 0);
    chk("ignore_hours", hours, 0);
    chk("ignore_minutes", minutes, 59);
    chk("ignore_seconds", seconds, 59);
    expect_no_dv("ignore_second_dv", 40);

    // Reset mid-conversion aborts and clears outputs.
    start_req(50000);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dv", dv, 0);
    chk("abort_fields", {hours, minutes, seconds}, 0);
    expect_no_dv("abort_no_dv", 40);
    do_conv("restart", 50000, 0, 13, 53, 20);

    // Randomized sweep against plain arithmetic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 86399);
      do_conv($sformatf("rnd%0d_%0d", i, r), r, 0, r / 3600, (r % 3600) / 60, r % 60);
      @(posedge clk);
      #1;
      chk("rnd_dv_width", dv, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
